// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the mesh router: flit field layout, flit type
// encodings and port index constants.
// No ports (package).
// ---------------------------------------------------------------------------
package noc_pkg;

    // Flit field layout for the 40-bit flit
    localparam int SRC_MSB  = 39;
    localparam int SRC_LSB  = 36;
    localparam int DST_MSB  = 35;
    localparam int DST_LSB  = 32;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 2;
    localparam int TYPE_MSB = 1;
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = TYPE_MSB - TYPE_LSB + 1;

    // Flit type encodings
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Port indices
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

endpackage

// File: rtl/switch_alloc_n_if.sv
// ---------------------------------------------------------------------------
// switch_alloc_n_if
// Bundles the allocator's request/crossbar signals.
//   in_label  : per-input one-hot requested output (NPORTS*NPORTS)
//   in_data   : head flit of each input FIFO (NPORTS*DATASIZE)
//   out_full  : per-output downstream full
//   in_ready  : per-input pop (combinational grant)
//   out_valid : per-output registered valid
//   out_data  : per-output registered flit
// Modports: master = the router side driving requests, slave = the allocator.
//
// Handshake: an input flit is transferred when its label is non-zero and
// in_ready is 1 in the same cycle; the FIFO pops at that rising edge.
// out_full acts as an inverted ready on each output: while it is 1 nothing
// is granted to that output, and out_valid is a one-cycle strobe with no
// further acknowledgement.
// ---------------------------------------------------------------------------
interface switch_alloc_n_if #(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40
);
    logic [NPORTS*NPORTS-1:0]   in_label;
    logic [NPORTS*DATASIZE-1:0] in_data;
    logic [NPORTS-1:0]          out_full;
    logic [NPORTS-1:0]          in_ready;
    logic [NPORTS-1:0]          out_valid;
    logic [NPORTS*DATASIZE-1:0] out_data;

    modport master (
        output in_label, in_data, out_full,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_label, in_data, out_full,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/switch_alloc_n_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for one output. The search starts at the internal
// pointer; the pointer moves to winner+1 (mod N) on every grant.
//   clk, rst : clock, async active-high reset (pointer -> 0)
//   req      : request vector
//   en       : output eligible; no grant is produced when low
//   grant    : one-hot grant
//   gidx     : index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx
);
    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            // Wrap the rotated index back into 0..N-1
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && en && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en && |grant) begin
            ptr_q <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
        end
    end
endmodule

// File: rtl/switch_alloc_n.sv
// ---------------------------------------------------------------------------
// switch_alloc_n
// N-port switch allocator: one round-robin arbiter per output, output
// back-pressure via out_full, and a registered crossbar stage.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : switch_alloc_n_if.slave (in_label, in_data, out_full in;
//          in_ready, out_valid, out_data out)
// Optional feature: define SA_WORMHOLE_LOCK_EN to keep each output locked
// to an input from a head flit until its tail flit.
// ---------------------------------------------------------------------------
module switch_alloc_n
    import noc_pkg::*;
#(
    parameter int NPORTS   = 5,
    parameter int DATASIZE = 40
) (
    input  logic            clk,
    input  logic            rst,
    switch_alloc_n_if.slave bus
);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]          low_label [NPORTS];  // per input
    logic [NPORTS-1:0]          req_raw   [NPORTS];  // per output, bit i = input i
    logic [NPORTS-1:0]          req       [NPORTS];
    logic [NPORTS-1:0]          grant     [NPORTS];
    logic [IW-1:0]              gidx      [NPORTS];
    logic [DATASIZE-1:0]        sel_data  [NPORTS];
    logic [NPORTS-1:0]          en;
    logic [NPORTS-1:0]          ready;
    logic [NPORTS-1:0]          out_valid_q;
    logic [NPORTS*DATASIZE-1:0] out_data_q;

`ifdef SA_WORMHOLE_LOCK_EN
    logic [NPORTS-1:0] lock_q;
    logic [IW-1:0]     lock_idx_q [NPORTS];
`endif

    // Keep only the lowest set label bit, then transpose to per-output requests
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            low_label[i] = bus.in_label[i*NPORTS +: NPORTS]
                         & (~bus.in_label[i*NPORTS +: NPORTS] + NPORTS'(1));
        end
        for (int o = 0; o < NPORTS; o++) begin
            req_raw[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req_raw[o][i] = low_label[i][o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req[o] = '0;
`ifdef SA_WORMHOLE_LOCK_EN
            if (lock_q[o]) begin
                // Locked: only the owning input may compete
                req[o][lock_idx_q[o]] = req_raw[o][lock_idx_q[o]];
            end else begin
                // Unlocked: a stray body flit has no packet to belong to
                for (int i = 0; i < NPORTS; i++) begin
                    req[o][i] = req_raw[o][i]
                              && (bus.in_data[i*DATASIZE + TYPE_LSB +: TYPE_W] != FLIT_BODY);
                end
            end
`else
            req[o] = req_raw[o];
`endif
        end
    end

    assign en = ~bus.out_full & {NPORTS{~rst}};

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter #(.N(NPORTS)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (req[o]),
            .en    (en[o]),
            .grant (grant[o]),
            .gidx  (gidx[o])
        );
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            sel_data[o] = bus.in_data[int'(gidx[o])*DATASIZE +: DATASIZE];
        end
        for (int i = 0; i < NPORTS; i++) begin
            ready[i] = 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                ready[i] = ready[i] | grant[o][i];
            end
        end
    end

    // Crossbar register: data holds when an output is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (|grant[o]) begin
                    out_valid_q[o]                      <= 1'b1;
                    out_data_q[o*DATASIZE +: DATASIZE] <= sel_data[o];
                end else begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

`ifdef SA_WORMHOLE_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            for (int o = 0; o < NPORTS; o++) lock_idx_q[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (|grant[o]) begin
                    if (sel_data[o][TYPE_LSB +: TYPE_W] == FLIT_HEAD) begin
                        lock_q[o]     <= 1'b1;
                        lock_idx_q[o] <= gidx[o];
                    end else if (sel_data[o][TYPE_LSB +: TYPE_W] == FLIT_TAIL) begin
                        lock_q[o] <= 1'b0;
                    end
                end
            end
        end
    end
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_switch_alloc_n.sv
// ---------------------------------------------------------------------------
// tb_switch_alloc_n
// Directed bench for switch_alloc_n (NPORTS=5, DATASIZE=40). Inputs change
// on the falling edge; combinational in_ready is sampled 1 ns later and the
// registered outputs on the following falling edge.
// ---------------------------------------------------------------------------
module tb_switch_alloc_n;
    import noc_pkg::*;

    localparam int NP = 5;
    localparam int DW = 40;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    switch_alloc_n_if #(.NPORTS(NP), .DATASIZE(DW)) bus ();

    switch_alloc_n #(.NPORTS(NP), .DATASIZE(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [NP*DW-1:0] obs,
                         input logic [NP*DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mk_flit(input int i, input logic [1:0] t);
        return {4'(i), 4'hA, 8'(i * 17), 22'(i * 4099 + 5), t};
    endfunction

    task automatic clear_inputs();
        bus.in_label = '0;
        bus.in_data  = '0;
        bus.out_full = '0;
    endtask

    task automatic set_req(input int i, input int o, input logic [DW-1:0] d);
        bus.in_label[i*NP +: NP] = NP'(1) << o;
        bus.in_data[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus tables ----------------
    int win_rr [6] = '{1, 3, 4, 1, 3, 4};
    int win_bp [8] = '{1, 3, -1, -1, -1, 4, 1, 3};
    logic [1:0] wh_type [4] = '{FLIT_HEAD, FLIT_BODY, FLIT_BODY, FLIT_TAIL};
`ifdef SA_WORMHOLE_LOCK_EN
    logic [NP-1:0] wh_exp [6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00010, 5'b00010};
`else
    logic [NP-1:0] wh_exp [6] = '{5'b00100, 5'b00010, 5'b00100, 5'b00010, 5'b00100, 5'b00010};
`endif

    initial begin
        int p;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", NP*DW'(bus.out_valid), '0);
        check("rst_data", bus.out_data, '0);
        rst = 1'b0;
        #1 check("idle_ready", NP*DW'(bus.in_ready), '0);

        // Single path: input 0 -> output E
        @(negedge clk);
        set_req(PORT_L, PORT_E, 40'h12_3456_789A);
        #1 check("single_ready", NP*DW'(bus.in_ready), NP*DW'(5'b00001));
        @(negedge clk);
        clear_inputs();
        check("single_valid", NP*DW'(bus.out_valid), NP*DW'(5'b00100));
        check("single_data", NP*DW'(bus.out_data[2*DW +: DW]), NP*DW'(40'h12_3456_789A));
        @(negedge clk);
        check("hold_valid", NP*DW'(bus.out_valid), '0);
        check("hold_data", NP*DW'(bus.out_data[2*DW +: DW]), NP*DW'(40'h12_3456_789A));

        // Asynchronous reset asserted mid-cycle
        #2 rst = 1'b1;
        #1 check("async_valid", NP*DW'(bus.out_valid), '0);
        check("async_data", bus.out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", NP*DW'(bus.in_ready), '0);

        // Round-robin fairness: inputs 1, 3, 4 -> output 0
        @(negedge clk);
        set_req(1, PORT_L, mk_flit(1, FLIT_SINGLE));
        set_req(3, PORT_L, mk_flit(3, FLIT_SINGLE));
        set_req(4, PORT_L, mk_flit(4, FLIT_SINGLE));
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("rr_ready_c%0d", c), NP*DW'(bus.in_ready),
                     NP*DW'(NP'(1) << win_rr[c]));
            @(negedge clk);
            check($sformatf("rr_valid_c%0d", c), NP*DW'(bus.out_valid[0]), NP*DW'(1'b1));
            check($sformatf("rr_data_c%0d", c), NP*DW'(bus.out_data[0 +: DW]),
                  NP*DW'(mk_flit(win_rr[c], FLIT_SINGLE)));
        end

        // Back-pressure: out_full[0] high in cycles 2..4
        do_reset();
        set_req(1, PORT_L, mk_flit(1, FLIT_SINGLE));
        set_req(3, PORT_L, mk_flit(3, FLIT_SINGLE));
        set_req(4, PORT_L, mk_flit(4, FLIT_SINGLE));
        for (int c = 0; c < 8; c++) begin
            bus.out_full[0] = (c >= 2 && c <= 4);
            #1 check($sformatf("bp_ready_c%0d", c), NP*DW'(bus.in_ready),
                     (win_bp[c] < 0) ? '0 : NP*DW'(NP'(1) << win_bp[c]));
            @(negedge clk);
            check($sformatf("bp_valid_c%0d", c + 1), NP*DW'(bus.out_valid[0]),
                  NP*DW'(win_bp[c] >= 0));
            if (win_bp[c] >= 0)
                check($sformatf("bp_data_c%0d", c + 1), NP*DW'(bus.out_data[0 +: DW]),
                      NP*DW'(mk_flit(win_bp[c], FLIT_SINGLE)));
        end

        // Parallel outputs: input i -> output (i+1) mod 5, two cycles
        clear_inputs();
        for (int i = 0; i < NP; i++) set_req(i, (i + 1) % NP, mk_flit(i, FLIT_SINGLE));
        for (int c = 0; c < 2; c++) begin
            #1 check($sformatf("par_ready_c%0d", c), NP*DW'(bus.in_ready), NP*DW'(5'b11111));
            @(negedge clk);
            check($sformatf("par_valid_c%0d", c), NP*DW'(bus.out_valid), NP*DW'(5'b11111));
            for (int o = 0; o < NP; o++)
                check($sformatf("par_data_o%0d", o), NP*DW'(bus.out_data[o*DW +: DW]),
                      NP*DW'(mk_flit((o + NP - 1) % NP, FLIT_SINGLE)));
        end

        // Multi-bit label uses lowest bit; self-loop 3 -> 3
        clear_inputs();
        bus.in_label[2*NP +: NP] = 5'b10100;
        bus.in_data[2*DW +: DW]  = mk_flit(2, FLIT_SINGLE);
        set_req(3, 3, mk_flit(3, FLIT_SINGLE));
        #1 check("multi_ready", NP*DW'(bus.in_ready), NP*DW'(5'b01100));
        @(negedge clk);
        check("multi_valid", NP*DW'(bus.out_valid), NP*DW'(5'b01100));
        check("multi_data2", NP*DW'(bus.out_data[2*DW +: DW]), NP*DW'(mk_flit(2, FLIT_SINGLE)));
        check("self_data3", NP*DW'(bus.out_data[3*DW +: DW]), NP*DW'(mk_flit(3, FLIT_SINGLE)));

        // Packet from input 2 vs single flits from input 1, both to output 4
        do_reset();
        p = 0;
        for (int c = 0; c < 6; c++) begin
            if (p < 4) set_req(2, PORT_W, mk_flit(2, wh_type[p]));
            else bus.in_label[2*NP +: NP] = '0;
            if (c >= 1) set_req(1, PORT_W, mk_flit(1, FLIT_SINGLE));
            #1 check($sformatf("wh_ready_c%0d", c), NP*DW'(bus.in_ready), NP*DW'(wh_exp[c]));
            if (wh_exp[c][2]) p++;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
